icmp_engine_arbiter: RTL and testbench

Sequencer and round-robin arbiter that shares one ICMP send/read engine between up to NREQ requesters. It turns held request levels into the engine's single-cycle `sendmode`/`readmode` launch strobes and holds the grant for the engine's fixed job length. It also counts `outputvalid` beats on send jobs and drives the engine's active-high `hardreset`. It sits between the packet-scheduling logic and the ICMP engine instance; the requester muxes payload/header inputs onto the engine using `grant`.

---
 rtl/icmp_engine_arbiter.sv | 154 +++++++++++++++
 tb/tb_icmp_engine_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/icmp_engine_arbiter.sv
// icmp_engine_arbiter: round-robin sequencer sharing one ICMP send/read engine
// between NREQ requesters. It turns held request levels into single-cycle
// launch strobes and holds the grant for the engine's fixed job length. It also
// counts outputvalid beats on send jobs and drives the engine's hardreset.
// Optional feature macro: ICMP_ARB_READ_PRIO_EN. When it is defined, pending
// read requests take priority over all send requests.
module icmp_engine_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned SEND_CYCLES = 13,
    parameter int unsigned READ_CYCLES = 7,
    parameter int unsigned SEND_BEATS  = 5
) (
    input  logic            clock,
    input  logic            hardreset_n,
    input  logic [NREQ-1:0] req_send,
    input  logic [NREQ-1:0] req_read,
    input  logic            err_clr,
    input  logic            eng_outputvalid,
    output logic [NREQ-1:0] grant,
    output logic            grant_read,
    output logic            eng_sendmode,
    output logic            eng_readmode,
    output logic            eng_hardreset,
    output logic            busy,
    output logic            done,
    output logic            beat_err
);

    localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned MAX_CYC = (SEND_CYCLES > READ_CYCLES) ? SEND_CYCLES : READ_CYCLES;
    localparam int unsigned CNT_W   = $clog2(MAX_CYC);
    localparam int unsigned BEAT_W  = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LAUNCH  = 2'd1,
        S_RUN     = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t              r_state;
    logic [IDX_W-1:0]    r_ptr;
    logic [IDX_W-1:0]    r_win_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic [BEAT_W-1:0]   r_beats;
    logic                r_hr_stage;

    logic [NREQ-1:0]     w_elig;
    logic                w_found;
    logic [IDX_W-1:0]    w_win_idx;
    logic                w_win_read;
    logic [IDX_W-1:0]    w_ptr_next;
    int unsigned         w_idx;

    // Eligibility mask and first-eligible search upward from the pointer, wrapping
    always_comb begin
        w_elig    = req_send | req_read;
`ifdef ICMP_ARB_READ_PRIO_EN
        if (|req_read) begin
            w_elig = req_read;
        end
`endif
        w_found   = 1'b0;
        w_win_idx = '0;
        w_idx     = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= NREQ) begin
                w_idx = w_idx - NREQ;
            end
            if (!w_found && w_elig[IDX_W'(w_idx)]) begin
                w_found   = 1'b1;
                w_win_idx = IDX_W'(w_idx);
            end
        end
        w_win_read = req_read[w_win_idx];
        w_ptr_next = (r_win_idx == IDX_W'(NREQ - 1)) ? '0 : r_win_idx + IDX_W'(1);
    end

    // Job sequencer: IDLE -> LAUNCH -> RUN -> RELEASE, plus hardreset stretch and beat check
    always_ff @(posedge clock) begin
        if (!hardreset_n) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_win_idx     <= '0;
            r_cnt         <= '0;
            r_beats       <= '0;
            r_hr_stage    <= 1'b1;
            grant         <= '0;
            grant_read    <= 1'b0;
            eng_sendmode  <= 1'b0;
            eng_readmode  <= 1'b0;
            eng_hardreset <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            beat_err      <= 1'b0;
        end else begin
            // Engine reset is held one extra cycle past the release of hardreset_n
            r_hr_stage    <= 1'b0;
            eng_hardreset <= r_hr_stage;
            done          <= 1'b0;
            eng_sendmode  <= 1'b0;
            eng_readmode  <= 1'b0;
            if (err_clr) begin
                beat_err <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (!eng_hardreset && w_found) begin
                        grant        <= NREQ'(1) << w_win_idx;
                        grant_read   <= w_win_read;
                        r_win_idx    <= w_win_idx;
                        eng_sendmode <= ~w_win_read;
                        eng_readmode <= w_win_read;
                        busy         <= 1'b1;
                        r_state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= grant_read ? CNT_W'(READ_CYCLES - 2) : CNT_W'(SEND_CYCLES - 2);
                    r_beats <= '0;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (eng_outputvalid && (r_beats != '1)) begin
                        r_beats <= r_beats + BEAT_W'(1);
                    end
                    if (r_cnt == '0) begin
                        done    <= 1'b1;
                        r_state <= S_RELEASE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_RELEASE: begin
                    // A failing beat check overrides a coincident err_clr
                    if (!grant_read && (r_beats != BEAT_W'(SEND_BEATS))) begin
                        beat_err <= 1'b1;
                    end
                    r_ptr      <= w_ptr_next;
                    grant      <= '0;
                    grant_read <= 1'b0;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icmp_engine_arbiter.sv
// Testbench for icmp_engine_arbiter: table of request sessions checked against
// a scoreboard of expected grants, plus hand sequences for reset and beat_err.
module tb_icmp_engine_arbiter;

    localparam int SC = 13;
    localparam int RC = 7;

    logic       clk;
    logic       hardreset_n;
    logic [3:0] req_send;
    logic [3:0] req_read;
    logic       err_clr;
    logic       eng_outputvalid;
    logic [3:0] grant;
    logic       grant_read;
    logic       eng_sendmode;
    logic       eng_readmode;
    logic       eng_hardreset;
    logic       busy;
    logic       done;
    logic       beat_err;

    int n_vec = 0;
    int n_err = 0;
    int beats_cfg = 5;
    int ov_left;

    typedef struct {
        logic [3:0]  g;
        logic        r;
    } sb_item_t;

    typedef struct {
        logic [3:0]  rs;
        logic [3:0]  rr;
        int          beats;
        int          n;
        logic [15:0] g;
        logic [3:0]  r;
        logic        err;
    } vec_t;

    sb_item_t sb[$];
    vec_t     vecs[6];

    icmp_engine_arbiter dut (
        .clock           (clk),
        .hardreset_n     (hardreset_n),
        .req_send        (req_send),
        .req_read        (req_read),
        .err_clr         (err_clr),
        .eng_outputvalid (eng_outputvalid),
        .grant           (grant),
        .grant_read      (grant_read),
        .eng_sendmode    (eng_sendmode),
        .eng_readmode    (eng_readmode),
        .eng_hardreset   (eng_hardreset),
        .busy            (busy),
        .done            (done),
        .beat_err        (beat_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: outputvalid for beats_cfg cycles right after a send strobe
    always @(posedge clk) begin
        if (!hardreset_n)
            ov_left <= 0;
        else if (eng_sendmode)
            ov_left <= beats_cfg;
        else if (ov_left != 0)
            ov_left <= ov_left - 1;
    end
    assign eng_outputvalid = (ov_left != 0);

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output int wc, output bit ok);
        wc = 0;
        do begin
            tick();
            wc++;
        end while (grant == 4'b0 && wc < 40);
        ok = (grant != 4'b0);
        if (!ok) timeout("grant_wait");
    endtask

    task automatic wait_done(output int dc, output bit ok);
        dc = 0;
        do begin
            tick();
            dc++;
            if (dc == 1) check("strobe_one_cycle", int'(eng_sendmode | eng_readmode), 0);
        end while (!done && dc < 40);
        ok = done;
        if (!ok) timeout("done_wait");
    endtask

    // Apply one request pattern; serve n jobs against the scoreboard
    task automatic run_session(input vec_t v);
        int wc, dc;
        bit ok;
        sb_item_t e, it;
        beats_cfg = v.beats;
        for (int i = 0; i < v.n; i++) begin
            it.g = v.g[4*i +: 4];
            it.r = v.r[i];
            sb.push_back(it);
        end
        req_send = v.rs;
        req_read = v.rr;
        for (int j = 0; j < v.n; j++) begin
            wait_grant(wc, ok);
            if (!ok) begin
                sb.delete();
                return;
            end
            e = sb.pop_front();
            check("grant", int'(grant), int'(e.g));
            check("grant_read", int'(grant_read), int'(e.r));
            check("sendmode", int'(eng_sendmode), int'(!e.r));
            check("readmode", int'(eng_readmode), int'(e.r));
            check("busy_launch", int'(busy), 1);
            if (j != 0) check("idle_gap", wc, 2);
            wait_done(dc, ok);
            if (!ok) begin
                sb.delete();
                return;
            end
            check("done_latency", dc, e.r ? RC : SC);
            req_send = req_send & ~grant;
            req_read = req_read & ~grant;
        end
        tick();
        check("grant_free", int'(grant), 0);
        check("busy_idle", int'(busy), 0);
        check("beat_err", int'(beat_err), int'(v.err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int wc, dc;
        bit ok;

        vecs[0] = '{rs: 4'b0010, rr: 4'b0000, beats: 5, n: 1, g: 16'h0002, r: 4'b0000, err: 1'b0};
        vecs[1] = '{rs: 4'b1111, rr: 4'b0000, beats: 5, n: 4, g: 16'h2184, r: 4'b0000, err: 1'b0};
        vecs[2] = '{rs: 4'b0001, rr: 4'b0001, beats: 5, n: 1, g: 16'h0001, r: 4'b0001, err: 1'b0};
        vecs[3] = '{rs: 4'b1000, rr: 4'b0000, beats: 5, n: 1, g: 16'h0008, r: 4'b0000, err: 1'b0};
`ifdef ICMP_ARB_READ_PRIO_EN
        vecs[4] = '{rs: 4'b0001, rr: 4'b0100, beats: 5, n: 2, g: 16'h0014, r: 4'b0001, err: 1'b0};
`else
        vecs[4] = '{rs: 4'b0001, rr: 4'b0100, beats: 5, n: 2, g: 16'h0041, r: 4'b0010, err: 1'b0};
`endif
        vecs[5] = '{rs: 4'b0100, rr: 4'b0000, beats: 4, n: 1, g: 16'h0004, r: 4'b0000, err: 1'b1};

        hardreset_n = 1'b0;
        req_send    = '0;
        req_read    = '0;
        err_clr     = 1'b0;

        // Reset values
        repeat (3) tick();
        check("rst_grant", int'(grant), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_strobes", int'({eng_sendmode, eng_readmode}), 0);
        check("rst_beat_err", int'(beat_err), 0);
        check("rst_hardreset", int'(eng_hardreset), 1);
        hardreset_n = 1'b1;
        tick();
        check("hardreset_stretch", int'(eng_hardreset), 1);
        tick();
        check("hardreset_drop", int'(eng_hardreset), 0);

        foreach (vecs[i]) run_session(vecs[i]);

        // beat_err is sticky until err_clr
        repeat (3) tick();
        check("beat_err_held", int'(beat_err), 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("beat_err_cleared", int'(beat_err), 0);

        // err_clr coinciding with a failing RELEASE leaves beat_err set
        beats_cfg = 3;
        req_send  = 4'b0100;
        wait_grant(wc, ok);
        if (ok) begin
            check("err_job_grant", int'(grant), 4'b0100);
            wait_done(dc, ok);
            if (ok) begin
                err_clr  = 1'b1;
                req_send = '0;
                tick();
                err_clr = 1'b0;
                check("beat_err_set_wins", int'(beat_err), 1);
            end
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("beat_err_cleared2", int'(beat_err), 0);

        // Mid-job reset; pointer (now 3) must return to 0
        beats_cfg = 5;
        req_send  = 4'b0100;
        wait_grant(wc, ok);
        if (ok) begin
            check("pre_reset_grant", int'(grant), 4'b0100);
            repeat (4) tick();
            check("pre_reset_busy", int'(busy), 1);
            hardreset_n = 1'b0;
            req_send    = 4'b1111;
            tick();
            check("midrst_grant", int'(grant), 0);
            check("midrst_busy", int'(busy), 0);
            check("midrst_done", int'(done), 0);
            check("midrst_hardreset", int'(eng_hardreset), 1);
            tick();
            hardreset_n = 1'b1;
            tick();
            check("midrst_hr_stretch", int'(eng_hardreset), 1);
            check("midrst_ignore1", int'(grant), 0);
            check("midrst_no_done", int'(done), 0);
            tick();
            check("midrst_hr_drop", int'(eng_hardreset), 0);
            check("midrst_ignore2", int'(grant), 0);
            tick();
            check("midrst_ptr_zero", int'(grant), 4'b0001);
            check("midrst_sendmode", int'(eng_sendmode), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
